axi4_lite_er_slave_regs: RTL and testbench

AXI4-Lite subordinate register file that answers the AXI4-Lite master VIP in the AXI4_Lite_ER block design. It provides NUM_REGS 32-bit read/write registers and accepts AW and W in either order, with one outstanding transaction per direction. Byte strobes are honoured. It sits behind the VIP master in the BD wrapper and serves as the register bank of the AXI4_Lite_ER IP.

---
 rtl/axi4_lite_er_pkg.sv | 16 +
 rtl/axi4_lite_er_wr_join.sv | 70 +++++++
 rtl/axi4_lite_er_slave_regs.sv | 141 ++++++++++++++
 tb/tb_axi4_lite_er_slave_regs.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_er_pkg.sv
// Shared constants and types for the AXI4_Lite_ER register bank.
// AXI response codes, word-address offset and register-index type.
package axi4_lite_er_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Byte address bits below this select a byte within a 32-bit word.
  localparam int ADDR_LSB = 2;

  // Wide enough to index the word slots of any supported address width.
  localparam int REG_IDX_W = 8;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage : axi4_lite_er_pkg

// File: rtl/axi4_lite_er_wr_join.sv
// Joins the independent AW and W channels into a single write commit.
// Either channel may arrive first; it is held until its partner shows up.
module axi4_lite_er_wr_join
  import axi4_lite_er_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                live,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  input  logic                bvalid,
  output logic                commit,
  output logic [ADDR_W-1:0]   commit_addr,
  output logic [DATA_W-1:0]   commit_data,
  output logic [DATA_W/8-1:0] commit_strb
);

  logic                aw_held;
  logic                w_held;
  logic [ADDR_W-1:0]   aw_addr_q;
  logic [DATA_W-1:0]   w_data_q;
  logic [DATA_W/8-1:0] w_strb_q;
  logic                aw_hs;
  logic                w_hs;

  // Readies depend only on registered state, never on the incoming valids.
  assign awready = live & ~aw_held & ~bvalid;
  assign wready  = live & ~w_held  & ~bvalid;
  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;

  assign commit      = (aw_held | aw_hs) & (w_held | w_hs) & ~bvalid;
  assign commit_addr = aw_held ? aw_addr_q : awaddr;
  assign commit_data = w_held  ? w_data_q  : wdata;
  assign commit_strb = w_held  ? w_strb_q  : wstrb;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order; blocking here races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end else begin
        if (aw_hs) aw_held <= 1'b1;
        if (w_hs)  w_held  <= 1'b1;
      end
      if (aw_hs) aw_addr_q <= awaddr;
      if (w_hs) begin
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
    end
  end

endmodule : axi4_lite_er_wr_join

// File: rtl/axi4_lite_er_slave_regs.sv
// AXI4-Lite register bank: NUM_REGS byte-strobed 32-bit registers.
// Define AXI4_LITE_ER_DECERR_EN to answer unimplemented slots with DECERR.
module axi4_lite_er_slave_regs
  import axi4_lite_er_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_REGS           = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int AW     = C_S_AXI_ADDR_WIDTH;
  localparam int STRB_W = DW / 8;

`ifdef AXI4_LITE_ER_DECERR_EN
  localparam logic [1:0] UNMAPPED_RESP = RESP_DECERR;
`else
  localparam logic [1:0] UNMAPPED_RESP = RESP_OKAY;
`endif

  logic              live;
  logic              commit;
  logic [AW-1:0]     commit_addr;
  logic [DW-1:0]     commit_data;
  logic [STRB_W-1:0] commit_strb;
  reg_idx_t          wr_idx;
  reg_idx_t          rd_idx;
  logic              wr_mapped;
  logic              rd_mapped;
  logic              ar_hs;
  logic [DW-1:0]     rd_word;
  logic [DW-1:0]     regs [NUM_REGS];

  axi4_lite_er_wr_join #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) u_wr_join (
    .clk         (S_AXI_ACLK),
    .rst_n       (S_AXI_ARESETN),
    .live        (live),
    .awaddr      (S_AXI_AWADDR),
    .awvalid     (S_AXI_AWVALID),
    .awready     (S_AXI_AWREADY),
    .wdata       (S_AXI_WDATA),
    .wstrb       (S_AXI_WSTRB),
    .wvalid      (S_AXI_WVALID),
    .wready      (S_AXI_WREADY),
    .bvalid      (S_AXI_BVALID),
    .commit      (commit),
    .commit_addr (commit_addr),
    .commit_data (commit_data),
    .commit_strb (commit_strb)
  );

  assign wr_idx    = reg_idx_t'(commit_addr[AW-1:ADDR_LSB]);
  assign rd_idx    = reg_idx_t'(S_AXI_ARADDR[AW-1:ADDR_LSB]);
  assign wr_mapped = wr_idx < reg_idx_t'(NUM_REGS);
  assign rd_mapped = rd_idx < reg_idx_t'(NUM_REGS);

  assign S_AXI_ARREADY = live & ~S_AXI_RVALID;
  assign ar_hs         = S_AXI_ARVALID & S_AXI_ARREADY;

  // NOTE: this register array is reset explicitly because software expects
  // zeros after reset; that costs a reset net per flop instead of a RAM.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        for (int k = 0; k < STRB_W; k++) begin
          if (wr_idx == reg_idx_t'(i) && commit_strb[k])
            regs[i][8*k +: 8] <= commit_data[8*k +: 8];
        end
      end
    end
  end

  // NOTE: the default assignment first keeps this always_comb latch-free
  // when no slot matches.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == reg_idx_t'(i)) rd_word = regs[i];
    end
  end

  // Commit is gated by !BVALID, so set and clear never coincide.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      live         <= 1'b0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RRESP  <= RESP_OKAY;
      S_AXI_RDATA  <= '0;
    end else begin
      live <= 1'b1;
      if (commit) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= wr_mapped ? RESP_OKAY : UNMAPPED_RESP;
      end else if (S_AXI_BVALID && S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end
      // rd_word sees pre-edge register contents, so a same-edge write is not visible.
      if (ar_hs) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_word;
        S_AXI_RRESP  <= rd_mapped ? RESP_OKAY : UNMAPPED_RESP;
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

  logic unused;
  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[ADDR_LSB-1:0],
                    commit_addr[ADDR_LSB-1:0], RESP_SLVERR, RESP_DECERR};

endmodule : axi4_lite_er_slave_regs

// File: tb/tb_axi4_lite_er_slave_regs.sv
// Self-checking bench for axi4_lite_er_slave_regs against a word-array model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_axi4_lite_er_slave_regs;

  localparam int NUM_REGS = 4;
`ifdef AXI4_LITE_ER_DECERR_EN
  localparam logic [1:0] UNMAPPED = 2'b11;
`else
  localparam logic [1:0] UNMAPPED = 2'b00;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, arvalid, arready, rvalid, rready;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] model [NUM_REGS];

  always #5 clk = ~clk;

  axi4_lite_er_slave_regs dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready)
  );

  function automatic logic [1:0] exp_resp_of(input logic [5:0] a);
    return (a[5:2] < 4'd4) ? 2'b00 : UNMAPPED;
  endfunction

  function automatic logic [31:0] exp_data_of(input logic [5:0] a);
    if (a[5:2] < 4'd4) return model[a[3:2]];
    return 32'h0;
  endfunction

  function automatic void model_write(input logic [5:0] a, input logic [31:0] d,
                                     input logic [3:0] s);
    if (a[5:2] < 4'd4)
      for (int k = 0; k < 4; k++)
        if (s[k]) model[a[3:2]][8*k +: 8] = d[8*k +: 8];
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;
  endfunction

  // Present AW and W with independent start delays until both are accepted.
  task automatic issue_write(input logic [5:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    int c = 0;
    while (!(aw_done && w_done) && c < 40) begin
      @(negedge clk);
      vectors++;
      if (bvalid !== 1'b0) begin
        miscompares++;
        $display("FAIL early_bvalid: bvalid=%b expected 0 before both handshakes", bvalid);
      end
      if (aw_done) begin
        vectors++;
        if (awready !== 1'b0) begin
          miscompares++;
          $display("FAIL aw_held_ready: awready=%b expected 0", awready);
        end
      end
      if (w_done) begin
        vectors++;
        if (wready !== 1'b0) begin
          miscompares++;
          $display("FAIL w_held_ready: wready=%b expected 0", wready);
        end
      end
      awaddr  = addr;
      awprot  = 3'($urandom);
      wdata   = data;
      wstrb   = strb;
      awvalid = !aw_done && c >= aw_dly;
      wvalid  = !w_done && c >= w_dly;
      if (awvalid && awready) aw_done = 1'b1;
      if (wvalid && wready) w_done = 1'b1;
      c++;
    end
    if (!(aw_done && w_done)) begin
      miscompares++;
      $display("FAIL write_timeout: aw_done=%b w_done=%b expected both 1", aw_done, w_done);
    end
  endtask

  // Expect BVALID one cycle after the commit edge, stall BREADY, then release.
  task automatic collect_b(input int stall, input logic [1:0] exp);
    @(negedge clk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    for (int i = 0; i < stall; i++) begin
      vectors++;
      if (bvalid !== 1'b1 || bresp !== exp || awready !== 1'b0 || wready !== 1'b0) begin
        miscompares++;
        $display("FAIL b_stall: bvalid=%b bresp=%b awready=%b wready=%b expected 1 %b 0 0",
                 bvalid, bresp, awready, wready, exp);
      end
      @(negedge clk);
    end
    vectors++;
    if (bvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL b_latency: bvalid=%b expected 1", bvalid);
    end
    vectors++;
    if (bresp !== exp) begin
      miscompares++;
      $display("FAIL bresp: got %b expected %b", bresp, exp);
    end
    vectors++;
    if (awready !== 1'b0 || wready !== 1'b0) begin
      miscompares++;
      $display("FAIL b_ready_block: awready=%b wready=%b expected 0 0", awready, wready);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    vectors++;
    if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
      miscompares++;
      $display("FAIL b_release: bvalid=%b awready=%b wready=%b expected 0 1 1",
               bvalid, awready, wready);
    end
  endtask

  task automatic axi_read(input logic [5:0] addr, input int stall,
                          input logic [31:0] exp_data, input logic [1:0] exp_resp);
    bit done = 1'b0;
    int c = 0;
    while (!done && c < 40) begin
      @(negedge clk);
      araddr  = addr;
      arprot  = 3'($urandom);
      arvalid = 1'b1;
      if (arready) done = 1'b1;
      c++;
    end
    if (!done) begin
      miscompares++;
      $display("FAIL read_timeout: arready never seen for addr %h", addr);
    end
    @(negedge clk);
    arvalid = 1'b0;
    for (int i = 0; i < stall; i++) begin
      vectors++;
      if (rvalid !== 1'b1 || rdata !== exp_data || rresp !== exp_resp || arready !== 1'b0) begin
        miscompares++;
        $display("FAIL r_stall: rvalid=%b rdata=%h rresp=%b arready=%b expected 1 %h %b 0",
                 rvalid, rdata, rresp, arready, exp_data, exp_resp);
      end
      @(negedge clk);
    end
    vectors++;
    if (rvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL r_latency: rvalid=%b expected 1", rvalid);
    end
    vectors++;
    if (rdata !== exp_data) begin
      miscompares++;
      $display("FAIL rdata[%h]: got %h expected %h", addr, rdata, exp_data);
    end
    vectors++;
    if (rresp !== exp_resp) begin
      miscompares++;
      $display("FAIL rresp[%h]: got %b expected %b", addr, rresp, exp_resp);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    vectors++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      miscompares++;
      $display("FAIL r_release: rvalid=%b arready=%b expected 0 1", rvalid, arready);
    end
  endtask

  task automatic do_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int stall);
    logic [1:0] exp;
    exp = exp_resp_of(addr);
    issue_write(addr, data, strb, aw_dly, w_dly);
    model_write(addr, data, strb);
    collect_b(stall, exp);
  endtask

  task automatic do_read(input logic [5:0] addr, input int stall);
    axi_read(addr, stall, exp_data_of(addr), exp_resp_of(addr));
  endtask

  task automatic read_all();
    for (int i = 0; i < NUM_REGS; i++) do_read(6'(4 * i), 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0 ||
        bresp !== 2'b00 || rresp !== 2'b00 || rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: rdy/valid=%b bresp=%b rresp=%b rdata=%h expected all 0",
               {awready, wready, arready, bvalid, rvalid}, bresp, rresp, rdata);
    end
    rst_n = 1'b1;
    vectors++;
    if ({awready, wready, arready} !== 3'b000) begin
      miscompares++;
      $display("FAIL ready_before_live: got %b expected 000", {awready, wready, arready});
    end
    @(negedge clk);
    vectors++;
    if ({awready, wready, arready} !== 3'b111) begin
      miscompares++;
      $display("FAIL ready_after_live: got %b expected 111", {awready, wready, arready});
    end
    model_clear();
    read_all();
  endtask

  task automatic test_basic();
    for (int i = 0; i < NUM_REGS; i++) do_write(6'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < NUM_REGS; i++) axi_read(6'(4 * i), 0, 32'(i + 1), 2'b00);
  endtask

  task automatic test_w_before_aw();
    do_write(6'h04, 32'hA5A5A5A5, 4'hF, 3, 0, 0);
    axi_read(6'h04, 0, 32'hA5A5A5A5, 2'b00);
  endtask

  task automatic test_strobe();
    do_write(6'h08, 32'h03030303, 4'hF, 0, 0, 0);
    do_write(6'h08, 32'hFFFFFFFF, 4'b0101, 1, 0, 0);
    axi_read(6'h08, 0, 32'h03FF03FF, 2'b00);
  endtask

  task automatic test_bready_stall();
    do_write(6'h0C, $urandom, 4'hF, 0, 2, 5);
    do_read(6'h0C, 3);
  endtask

  task automatic test_unmapped();
    axi_read(6'h10, 0, 32'h0, UNMAPPED);
    do_write(6'h10, $urandom, 4'hF, 0, 0, 0);
    do_write(6'h3F, $urandom, 4'hF, 1, 0, 1);
    read_all();
    do_read(6'h3C, 0);
  endtask

  // AR and the write commit land on the same edge for the same register.
  task automatic test_collision();
    logic [31:0] old_val, new_val;
    old_val = model[1];
    new_val = $urandom;
    @(negedge clk);
    awaddr = 6'h04; wdata = new_val; wstrb = 4'hF; araddr = 6'h05;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    vectors++;
    if ({awready, wready, arready} !== 3'b111) begin
      miscompares++;
      $display("FAIL collide_ready: got %b expected 111", {awready, wready, arready});
    end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    vectors++;
    if (bvalid !== 1'b1 || rvalid !== 1'b1 || rdata !== old_val || bresp !== 2'b00 || rresp !== 2'b00) begin
      miscompares++;
      $display("FAIL collide_read_old: bvalid=%b rvalid=%b rdata=%h bresp=%b rresp=%b expected 1 1 %h 00 00",
               bvalid, rvalid, rdata, bresp, rresp, old_val);
    end
    model_write(6'h04, new_val, 4'hF);
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    vectors++;
    if (bvalid !== 1'b0 || rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL collide_release: bvalid=%b rvalid=%b expected 0 0", bvalid, rvalid);
    end
    do_read(6'h04, 0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    awaddr = 6'h08; awvalid = 1'b1;
    vectors++;
    if (awready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_aw_ready: awready=%b expected 1", awready);
    end
    @(negedge clk);
    awvalid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (bvalid !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_no_bvalid: bvalid=%b expected 0 (cycle %0d)", bvalid, i);
      end
      @(negedge clk);
    end
    read_all();
    do_write(6'h00, 32'h7, 4'hF, 2, 0, 0);
    axi_read(6'h00, 0, 32'h7, 2'b00);
    read_all();
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      logic [5:0] a;
      a = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 2));
      else
        do_read(a, $urandom_range(0, 2));
    end
    read_all();
  endtask

  initial begin
    rst_n = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    model_clear();
    test_reset();
    test_basic();
    test_w_before_aw();
    test_strobe();
    test_bready_stall();
    test_unmapped();
    test_collision();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_axi4_lite_er_slave_regs
